// File: rtl/rs_sched_pkg.sv
// Shared types and helpers for the reservation-station port scheduler.
package rs_sched_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sched_state_e;

  localparam int unsigned GRP_SIZE = 8;
  localparam int unsigned MAX_BUF  = 256;
  localparam int unsigned MAX_GRP  = MAX_BUF / GRP_SIZE;

  // OR-reduce each 8-entry group; callers zero-extend to MAX_BUF and truncate the result.
  function automatic logic [MAX_GRP-1:0] grp8(input logic [MAX_BUF-1:0] v);
    logic [MAX_GRP-1:0] g;
    g = '0;
    for (int unsigned i = 0; i < MAX_GRP; i++) g[i] = |v[i*GRP_SIZE +: GRP_SIZE];
    return g;
  endfunction

  // Index of the set bit of a one-hot vector (0 for an all-zero vector).
  function automatic logic [7:0] oh_index(input logic [MAX_BUF-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BUF; i++)
      if (v[i]) r = r | 8'(i);
    return r;
  endfunction

endpackage

// File: rtl/rs_rr_pick.sv
// Round-robin first-set pick: first bit of (req & ~mask) at or after ptr, wrapping.
module rs_rr_pick #(
  parameter int unsigned BUF_COUNT = 32
) (
  input  logic [BUF_COUNT-1:0]         req,
  input  logic [BUF_COUNT-1:0]         mask,
  input  logic [$clog2(BUF_COUNT)-1:0] ptr,
  output logic [BUF_COUNT-1:0]         pick,
  output logic                         found
);

  localparam int unsigned PW = $clog2(BUF_COUNT);

  // Returns {valid, index} of the lowest set bit.
  function automatic logic [PW:0] bit_find_first_bit(input logic [BUF_COUNT-1:0] v);
    logic [PW:0] r;
    r = '0;
    for (int i = BUF_COUNT - 1; i >= 0; i--)
      if (v[i]) r = {1'b1, PW'(i)};
    return r;
  endfunction

  logic [BUF_COUNT-1:0] eff;
  logic [BUF_COUNT-1:0] rot;
  logic [PW:0]          first;
  logic [PW:0]          sum;

  always_comb begin
    eff   = req & ~mask;
    rot   = BUF_COUNT'({eff, eff} >> ptr);
    first = bit_find_first_bit(rot);
    found = first[PW];
    sum   = {1'b0, first[PW-1:0]} + {1'b0, ptr};
    if (sum >= (PW+1)'(BUF_COUNT)) sum = sum - (PW+1)'(BUF_COUNT);
    pick  = found ? (BUF_COUNT'(1) << sum[PW-1:0]) : '0;
  end

endmodule

// File: rtl/rs_port_scheduler.sv
// Shares one RS buffer among several issue ports: round-robin grants per port,
// a starvation override onto port 0, and a short quiet window after a flush.
module rs_port_scheduler
  import rs_sched_pkg::*;
#(
  parameter int unsigned BUF_COUNT    = 32,
  parameter int unsigned PORTS        = 3,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    except,
  input  logic [BUF_COUNT-1:0]                    entryReady,
  input  logic [PORTS-1:0]                        portEn,
  output logic [PORTS*BUF_COUNT-1:0]              rsSelect,
  output logic [PORTS*(BUF_COUNT/GRP_SIZE)-1:0]   rsSel8,
  output logic [PORTS-1:0]                        found
);

  localparam int unsigned PW = $clog2(BUF_COUNT);
  localparam int unsigned NG = BUF_COUNT / GRP_SIZE;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  sched_state_e         state;
  logic [FW-1:0]        fcnt;
  logic [BUF_COUNT-1:0] pending, eligible, all_grants, s_onehot, r_pick;
  logic [PW-1:0]        ptr, ptr_next, s_idx;
  logic [CW-1:0]        s_cnt;
  logic                 s_valid, s_hit, override, r_found, run;

  always_comb begin
    run      = (state == RUN);
    eligible = entryReady & ~pending;
    s_hit    = s_valid & eligible[s_idx];
    s_onehot = BUF_COUNT'(1) << s_idx;
    override = run & s_hit & portEn[0] & (s_cnt == CW'(STARVE_LIMIT));
  end

  // Per-port chain: each port searches what lower ports left and passes on the pointer.
  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [BUF_COUNT-1:0] mask_in, pick, grant, taken;
    logic [PW-1:0]        gidx, nptr_in, nptr;
    logic                 pick_found, use_ovr, granted;

    if (p == 0) begin : g_head
      assign mask_in = '0;
      assign nptr_in = ptr;
      assign use_ovr = override;
    end else begin : g_tail
      assign mask_in = g_port[p-1].taken;
      assign nptr_in = g_port[p-1].nptr;
      assign use_ovr = 1'b0;
    end

    rs_rr_pick #(.BUF_COUNT(BUF_COUNT)) u_pick (
      .req   (eligible),
      .mask  (mask_in),
      .ptr   (ptr),
      .pick  (pick),
      .found (pick_found)
    );

    assign granted = run & portEn[p] & (use_ovr | pick_found);
    assign grant   = !granted ? '0 : (use_ovr ? s_onehot : pick);
    assign gidx    = use_ovr ? s_idx : PW'(oh_index(MAX_BUF'(pick)));
    assign taken   = mask_in | grant;
    assign nptr    = !granted ? nptr_in
                   : (gidx == PW'(BUF_COUNT - 1)) ? '0 : gidx + PW'(1);

    assign rsSelect[p*BUF_COUNT +: BUF_COUNT] = rst ? '0 : grant;
    assign rsSel8[p*NG +: NG]                 = rst ? '0 : NG'(grp8(MAX_BUF'(grant)));
    assign found[p]                           = ~rst & granted;
  end

  assign all_grants = g_port[PORTS-1].taken;
  assign ptr_next   = g_port[PORTS-1].nptr;

  // Candidate for the starvation tracker when it needs a new entry.
  rs_rr_pick #(.BUF_COUNT(BUF_COUNT)) u_reload (
    .req   (eligible),
    .mask  (all_grants),
    .ptr   (ptr),
    .pick  (r_pick),
    .found (r_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      fcnt    <= '0;
      pending <= '0;
      ptr     <= '0;
      s_idx   <= '0;
      s_valid <= 1'b0;
      s_cnt   <= '0;
    end else if (except) begin
      state   <= FLUSH;
      fcnt    <= '0;
      pending <= '0;
      ptr     <= '0;
      s_valid <= 1'b0;
      s_cnt   <= '0;
    end else if (state == FLUSH) begin
      if (fcnt == FW'(FLUSH_CYCLES - 1)) state <= RUN;
      fcnt <= fcnt + FW'(1);
    end else begin
      pending <= (pending | all_grants) & entryReady;
      ptr     <= ptr_next;
      if (s_hit && !all_grants[s_idx]) begin
        if (s_cnt != CW'(STARVE_LIMIT)) s_cnt <= s_cnt + CW'(1);
      end else begin
        s_valid <= r_found;
        s_idx   <= PW'(oh_index(MAX_BUF'(r_pick)));
        s_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rs_port_scheduler.sv
// Randomized and directed checks of rs_port_scheduler against a behavioural model.
module tb_rs_port_scheduler;

  localparam int B   = 32;
  localparam int P   = 3;
  localparam int NG  = B / 8;
  localparam int LIM = 15;
  localparam int FLC = 2;

  logic           clk = 1'b0;
  logic           rst, except;
  logic [B-1:0]   entryReady;
  logic [P-1:0]   portEn;
  logic [P*B-1:0] rsSelect;
  logic [P*NG-1:0] rsSel8;
  logic [P-1:0]   found;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_pend[B];
  bit m_used[B];
  int m_ptr, m_sidx, m_scnt, m_flush;
  bit m_sval;
  int g[P];

  always #5 clk = ~clk;

  rs_port_scheduler #(
    .BUF_COUNT(B), .PORTS(P), .STARVE_LIMIT(LIM), .FLUSH_CYCLES(FLC)
  ) dut (
    .clk(clk), .rst(rst), .except(except), .entryReady(entryReady),
    .portEn(portEn), .rsSelect(rsSelect), .rsSel8(rsSel8), .found(found)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [B-1:0] oh(input int i);
    logic [B-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit elig(input int i);
    return entryReady[i] && !m_pend[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < B; i++) m_pend[i] = 0;
    m_ptr = 0; m_sval = 0; m_sidx = 0; m_scnt = 0; m_flush = 0;
  endtask

  task automatic model_grants();
    for (int i = 0; i < B; i++) m_used[i] = 0;
    for (int p = 0; p < P; p++) g[p] = -1;
    if (m_flush > 0) return;
    for (int p = 0; p < P; p++) begin
      if (!portEn[p]) continue;
      if (p == 0 && m_sval && m_scnt == LIM && elig(m_sidx)) g[p] = m_sidx;
      else
        for (int k = 0; k < B; k++) begin
          int i;
          i = (m_ptr + k) % B;
          if (elig(i) && !m_used[i]) begin g[p] = i; break; end
        end
      if (g[p] >= 0) m_used[g[p]] = 1;
    end
  endtask

  task automatic model_update();
    int last;
    if (except) begin
      m_flush = FLC;
      for (int i = 0; i < B; i++) m_pend[i] = 0;
      m_ptr = 0; m_sval = 0; m_scnt = 0;
    end else if (m_flush > 0) begin
      m_flush--;
    end else begin
      if (m_sval && elig(m_sidx) && !m_used[m_sidx]) begin
        if (m_scnt < LIM) m_scnt++;
      end else begin
        m_sval = 0; m_scnt = 0;
        for (int k = 0; k < B; k++) begin
          int i;
          i = (m_ptr + k) % B;
          if (elig(i) && !m_used[i]) begin m_sval = 1; m_sidx = i; break; end
        end
      end
      last = -1;
      for (int p = 0; p < P; p++) if (g[p] >= 0) last = g[p];
      if (last >= 0) m_ptr = (last + 1) % B;
      for (int i = 0; i < B; i++) m_pend[i] = (m_pend[i] || m_used[i]) && entryReady[i];
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [P*B-1:0]  es;
    logic [P*NG-1:0] e8;
    logic [P-1:0]    ef;
    es = '0; e8 = '0; ef = '0;
    for (int p = 0; p < P; p++)
      if (g[p] >= 0) begin
        es[p*B + g[p]]    = 1'b1;
        e8[p*NG + g[p]/8] = 1'b1;
        ef[p]             = 1'b1;
      end
    chk({tag, "_sel"},   128'(rsSelect), 128'(es));
    chk({tag, "_sel8"},  128'(rsSel8),   128'(e8));
    chk({tag, "_found"}, 128'(found),    128'(ef));
  endtask

  // One cycle: drive at negedge, check against model, advance model at posedge.
  // e0..e2: fixed expected grant per port (-1 none, -2 unchecked).
  task automatic step(input logic [B-1:0] rdy, input logic [P-1:0] en, input logic exc,
                      input string tag, input int e0 = -2, input int e1 = -2, input int e2 = -2);
    int ex[P];
    @(negedge clk);
    entryReady = rdy; portEn = en; except = exc;
    #1;
    model_grants();
    check_outputs(tag);
    ex = '{e0, e1, e2};
    for (int p = 0; p < P; p++)
      if (ex[p] != -2)
        chk($sformatf("%s_p%0d", tag, p), 128'(rsSelect[p*B +: B]), 128'(oh(ex[p])));
    @(posedge clk);
    model_update();
  endtask

  initial begin
    logic [B-1:0] r;
    rst = 1'b1; except = 1'b0; entryReady = '1; portEn = '1;
    model_reset();
    #1;
    chk("reset_sel",   128'(rsSelect), 128'(0));
    chk("reset_found", 128'(found),    128'(0));
    repeat (2) @(posedge clk);
    entryReady = '0; portEn = '0;
    @(negedge clk) rst = 1'b0;

    // basic three-port grant, then pointer at 7 and no regrant of 4..6
    step(32'h0000_00F0, 3'b111, 1'b0, "basic", 4, 5, 6);
    step(32'h0000_0274, 3'b111, 1'b0, "basic_ptr", 9, 2, -1);
    step(32'h0, 3'b000, 1'b0, "idle");
    step(32'h0, 3'b000, 1'b0, "no_elig", -1, -1, -1);

    // disabled middle port
    step(32'h0000_0003, 3'b101, 1'b0, "disabled", 0, -1, 1);
    step(32'h0, 3'b000, 1'b0, "idle");

    // wrap-around from pointer 30
    step(32'h2000_0000, 3'b001, 1'b0, "to30", 29, -1, -1);
    step(32'h0, 3'b000, 1'b0, "idle");
    step(32'h8000_0005, 3'b111, 1'b0, "wrap", 31, 0, 2);
    step(32'h0, 3'b000, 1'b0, "idle");
    step(32'h0000_0012, 3'b001, 1'b0, "after_wrap", 4, -1, -1);

    // flush with pending entries
    step(32'h0, 3'b000, 1'b0, "idle");
    step(32'h0000_00FF, 3'b111, 1'b0, "pre_flush");
    step(32'h0000_00FF, 3'b111, 1'b1, "except");
    step(32'h0000_00FF, 3'b111, 1'b0, "flush1", -1, -1, -1);
    step(32'h0000_00FF, 3'b111, 1'b0, "flush2", -1, -1, -1);
    step(32'h0000_00FF, 3'b111, 1'b0, "resume", 0, 1, 2);

    // starvation override onto port 0 (round-robin alone would pick entry 3)
    step(32'h0, 3'b000, 1'b1, "st_exc");
    step(32'h0, 3'b000, 1'b0, "st_fl");
    step(32'h0, 3'b000, 1'b0, "st_fl");
    step(32'h0000_0200, 3'b000, 1'b0, "st_load");
    repeat (20) step(32'h0000_0208, 3'b000, 1'b0, "st_wait");
    step(32'h0000_0208, 3'b001, 1'b0, "starve", 9, -1, -1);

    // randomized traffic
    r = '0;
    repeat (600) begin
      r = (r & ~($urandom() & $urandom())) | ($urandom() & $urandom() & $urandom());
      step(r, P'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0), "rnd");
    end
    repeat (400) begin
      r = (r & ~($urandom() & $urandom() & $urandom())) | ($urandom() & $urandom() & $urandom());
      step(r, {2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0)},
           ($urandom_range(0, 99) == 0), "rnd_starve");
    end

    // asynchronous reset in the middle of a granting cycle
    step(32'h0, 3'b000, 1'b1, "ar_exc");
    step(32'h0, 3'b000, 1'b0, "ar_fl");
    step(32'h0, 3'b000, 1'b0, "ar_fl");
    step(32'h0000_0300, 3'b011, 1'b0, "ar_pre", 8, 9, -2);
    @(negedge clk);
    entryReady = 32'h0000_3300; portEn = 3'b011; except = 1'b0;
    #1;
    model_grants();
    check_outputs("ar_mid");
    #2 rst = 1'b1;
    #1;
    chk("ar_sel",   128'(rsSelect), 128'(0));
    chk("ar_sel8",  128'(rsSel8),   128'(0));
    chk("ar_found", 128'(found),    128'(0));
    model_reset();
    entryReady = '0; portEn = '0;
    @(negedge clk) rst = 1'b0;
    step(32'h0000_3300, 3'b011, 1'b0, "ar_post", 8, 9, -2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_port_scheduler.md
# rs_port_scheduler

Shares one reservation-station buffer of `BUF_COUNT` entries among `PORTS` issue ports. Each cycle it picks up to one ready entry per enabled port. Picks are round-robin from a rotating pointer, and a starvation override forces a long-waiting entry onto port 0. It sits between the RS ready-vector logic and the per-port issue muxes, and replaces per-port find-first selection when several ports drain one buffer.

## Interface
- `BUF_COUNT`, 32: RS entries; must be a multiple of 8.
- `PORTS`, 3: issue ports sharing the buffer.
- `STARVE_LIMIT`, 15: cycles an entry may stay eligible without a grant before the override fires.
- `FLUSH_CYCLES`, 2: quiet cycles after `except`.

Ports:
- `clk`  in  1  clock, one domain.
- `rst`  in  1  asynchronous, active-high reset.
- `except`  in  1  synchronous pipeline flush.
- `entryReady`  in  BUF_COUNT  entry is valid and operands are ready.
- `portEn`  in  PORTS  port p can accept an issue this cycle.
- `rsSelect`  out  PORTS*BUF_COUNT  one-hot grant per port; slice p is `[p*BUF_COUNT +: BUF_COUNT]`.
- `rsSel8`  out  PORTS*(BUF_COUNT/8)  one-hot 8-entry group of each grant.
- `found`  out  PORTS  port p granted this cycle.

## Operation
- **State:**
  - `pending[BUF_COUNT]`: granted entries whose ready bit is still up.
  - `ptr[$clog2(BUF_COUNT)]`: round-robin start index.
  - Starvation tracker: `sIdx`, `sValid`, `sCnt` (5 bits).
  - FSM state plus flush counter.
- **Eligible** = `entryReady & ~pending`.
- **FSM states:**
  - RUN: normal granting.
  - FLUSH: all outputs 0; counts `FLUSH_CYCLES`, then returns to RUN.
  - `except` in any state: enter FLUSH, clear `pending`, `ptr`=0, `sValid`=0.
  - `except` held high keeps the FSM in FLUSH and restarts the count.
- **Grant order in RUN**, ports processed 0..PORTS-1:
  - Override: if `sValid`, `sCnt`==`STARVE_LIMIT`, `portEn[0]`, and `sIdx` is eligible, port 0 grants `sIdx`.
  - Every other enabled port grants the first eligible entry at or after `ptr`, wrapping at `BUF_COUNT-1`→0, excluding entries granted to lower ports this cycle.
  - A disabled port outputs 0 and consumes nothing; higher ports still search the full remaining set.
  - No two ports are ever granted the same entry.
- **pending update:**
  - `pending` ← (`pending` | all grants) & `entryReady`.
  - A bit therefore clears the cycle after the RS drops ready, i.e. the entry is deallocated.
- **ptr update:**
  - If any grant occurred, `ptr` ← (index of the grant on the highest-numbered granting port) + 1, mod `BUF_COUNT`.
  - Otherwise `ptr` is unchanged.
- **Starvation tracker:**
  - If `sValid`, `sIdx` is eligible and not granted: `sCnt` increments, saturating at `STARVE_LIMIT`.
  - If `sIdx` is granted or becomes ineligible: reload `sIdx` with the first eligible, ungranted entry at or after `ptr` (`sValid`=0 if none), and set `sCnt`=0.
  - If `sValid`=0: load the same way.
- `rsSel8` slice p = OR-reduce of each 8-bit group of `rsSelect` slice p.

## Timing
- **Reset (`rst` high, async):**
  - `pending`=0, `ptr`=0, `sValid`=0, `sCnt`=0, state RUN.
  - `rsSelect`, `rsSel8`, `found` forced to 0 while `rst` is high.
- **Grant latency:** combinational, the same cycle as `entryReady`/`portEn`. All state updates take effect at the next `clk` edge.
- An entry granted in cycle N is masked from cycle N+1 until its ready bit drops.
- **After `except` at edge N:**
  - Outputs are 0 for `FLUSH_CYCLES` cycles.
  - The first grant is possible in cycle N+`FLUSH_CYCLES`+1.
- **Override timing:** an entry continuously eligible and ungranted for `STARVE_LIMIT` consecutive cycles is granted to port 0 in the following cycle, provided `portEn[0]`=1.
  - If `portEn[0]`=0, the override waits and `sCnt` holds at `STARVE_LIMIT`.
- **Boundaries:**
  - No eligible entries: all `found`=0 and `ptr` holds.
  - More enabled ports than eligible entries: the surplus high ports show `found`=0.
  - Wrap-around: with `ptr`=30 and entries {31,0,2} eligible, ports get 31, 0, 2.

## Structure
- **`rs_sched_pkg`:** FSM state enum (`RUN`, `FLUSH`), group size constant 8, and the helper function `grp8()` (OR-reduce per 8-entry group).
- **Sub-module `rs_rr_pick`:**
  - Inputs: `BUF_COUNT`-wide request and mask, plus a start pointer.
  - Outputs: one-hot pick and found.
  - Implementation: double-width rotate plus `bit_find_first_bit`.
  - Instantiated once per port and once for tracker reload.

## Test plan
- **Three ports, basic grant:** reset, `portEn`=3'b111, `entryReady`=0x0000_00F0 → ports get entries 4, 5, 6; `ptr`=7 next cycle; entries 4–6 are not regranted while ready stays high.
- **Disabled port:** `portEn`=3'b101, `entryReady`=0x3 → port0=0, port1 `found`=0, port2=1.
- **Wrap-around:** `ptr`=30, eligible {31,0,2} → grants 31, 0, 2, then `ptr`=3.
- **Starvation:** only `portEn[1]` and `portEn[2]` active, plus a steady stream that keeps entry 9 losing round-robin for 15 cycles; then raise `portEn[0]` → port 0 grants 9 that cycle.
- **Flush:** `except` pulse with `pending` nonzero → outputs 0 for 2 cycles, `pending`=0, `ptr`=0, then grants resume from entry 0.
- **Async reset mid-operation:** assert `rst` between clock edges while grants are active → outputs 0 immediately and all state at reset values.
